// File: rtl/prga.sv
// RC4 pseudo-random generation stage: walks a length-prefixed ciphertext memory,
// advances i/j, swaps S entries and writes decrypted bytes to plaintext memory.
module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, GET_LEN, RD_SI, GET_SI, RD_SJ, GET_SJ, WR_SI, WR_SJ, RD_PAD, WR_PT
  } state_t;

  state_t     r_state;
  logic       r_rdy;
  logic [7:0] r_i, r_j, r_k, r_si, r_sj, r_len;
  logic [7:0] r_s_addr, r_s_wrdata, r_ct_addr, r_pt_addr;
  logic       r_s_wren, r_pt_wren;
  logic [7:0] w_pt_wrdata;

  // Outputs are registered one state ahead so they are valid during the named state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rdy      <= 1'b1;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_si       <= '0;
      r_sj       <= '0;
      r_len      <= '0;
      r_s_addr   <= '0;
      r_s_wrdata <= '0;
      r_s_wren   <= 1'b0;
      r_ct_addr  <= '0;
      r_pt_addr  <= '0;
      r_pt_wren  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= 8'd1;
            r_ct_addr <= '0;
            r_rdy     <= 1'b0;
            r_state   <= RD_LEN;
          end
        end
        RD_LEN: begin
          r_pt_addr <= '0;
          r_pt_wren <= 1'b1;
          r_state   <= GET_LEN;
        end
        GET_LEN: begin
          r_len     <= ct_rddata;
          r_pt_wren <= 1'b0;
          if (ct_rddata != 8'd0) begin
            r_s_addr  <= r_i + 8'd1;
            r_ct_addr <= r_k;
            r_state   <= RD_SI;
          end else begin
            r_rdy   <= 1'b1;
            r_state <= IDLE;
          end
        end
        RD_SI: begin
          r_i     <= r_i + 8'd1;
          r_state <= GET_SI;
        end
        GET_SI: begin
          r_si     <= s_rddata;
          r_j      <= r_j + s_rddata;
          r_s_addr <= r_j + s_rddata;
          r_state  <= RD_SJ;
        end
        RD_SJ: r_state <= GET_SJ;
        GET_SJ: begin
          r_sj       <= s_rddata;
          r_s_addr   <= r_i;
          r_s_wrdata <= s_rddata;
          r_s_wren   <= 1'b1;
          r_state    <= WR_SI;
        end
        WR_SI: begin
          r_s_addr   <= r_j;
          r_s_wrdata <= r_si;
          r_state    <= WR_SJ;
        end
        WR_SJ: begin
          r_s_wren <= 1'b0;
          r_s_addr <= r_si + r_sj;
          r_state  <= RD_PAD;
        end
        RD_PAD: begin
          r_pt_addr <= r_k;
          r_pt_wren <= 1'b1;
          r_state   <= WR_PT;
        end
        WR_PT: begin
          r_pt_wren <= 1'b0;
          if (r_k == r_len) begin
            r_rdy   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_k       <= r_k + 8'd1;
            r_ct_addr <= r_k + 8'd1;
            r_s_addr  <= r_i + 8'd1;
            r_state   <= RD_SI;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write data depends on memory read data arriving this cycle, so it cannot be registered.
  always_comb begin
    w_pt_wrdata = '0;
    if (r_state == GET_LEN)
      w_pt_wrdata = ct_rddata;
    else if (r_state == WR_PT)
      w_pt_wrdata = s_rddata ^ ct_rddata;
  end

  assign rdy       = r_rdy;
  assign s_addr    = r_s_addr;
  assign s_wrdata  = r_s_wrdata;
  assign s_wren    = r_s_wren;
  assign ct_addr   = r_ct_addr;
  assign pt_addr   = r_pt_addr;
  assign pt_wrdata = w_pt_wrdata;
  assign pt_wren   = r_pt_wren;

endmodule

// File: tb/tb_prga.sv
// Bench for prga: behavioural RC4 model, memories with 1-cycle read latency,
// and a per-cycle compare of write strobes, addresses, data and rdy.
module tb_prga;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       rdy, s_wren, pt_wren;
  logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;

  prga dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] S_mem[256], ct_mem[256], pt_mem[256], S_ld[256], ct_ld[256];
  bit         do_load = 1'b0;
  int         nswr = 0, nptwr = 0;

  always @(posedge clk) begin
    s_rddata  <= S_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (do_load) begin
      S_mem  <= S_ld;
      ct_mem <= ct_ld;
      for (int a = 0; a < 256; a++) pt_mem[a] <= 8'h00;
    end else begin
      if (s_wren) begin
        S_mem[s_addr] <= s_wrdata;
        nswr <= nswr + 1;
      end
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        nptwr <= nptwr + 1;
      end
    end
  end

  int checks = 0, errors = 0;
  int m_L;
  logic [7:0] m_i[256], m_j[256], m_wi[256], m_wj[256], m_pt[256], m_S[256];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Plain software RC4 PRGA over the current memory contents.
  task automatic model();
    logic [7:0] s[256];
    logic [7:0] ii, jj, t;
    s = S_mem;
    m_L = int'(ct_mem[0]);
    m_pt[0] = ct_mem[0];
    ii = 8'd0;
    jj = 8'd0;
    for (int k = 1; k <= m_L; k++) begin
      ii = ii + 8'd1;
      jj = jj + s[ii];
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      m_i[k] = ii; m_j[k] = jj; m_wi[k] = s[ii]; m_wj[k] = s[jj];
      t = s[ii] + s[jj];
      m_pt[k] = ct_mem[k] ^ s[t];
    end
    m_S = s;
  endtask

  task automatic compare(input int c);
    bit in_loop, pe, se;
    int k, ph;
    in_loop = (c >= 2) && (c < 2 + 8 * m_L);
    k  = in_loop ? (c - 2) / 8 + 1 : 0;
    ph = in_loop ? (c - 2) % 8 : -1;
    pe = (c == 1) || (ph == 7);
    se = (ph == 4) || (ph == 5);
    chk("rdy", int'(rdy), int'(c >= 2 + 8 * m_L));
    chk("pt_wren", int'(pt_wren), int'(pe));
    chk("s_wren", int'(s_wren), int'(se));
    if (in_loop) chk("ct_addr", int'(ct_addr), k);
    if (c == 1) begin
      chk("pt_addr_len", int'(pt_addr), 0);
      chk("pt_wrdata_len", int'(pt_wrdata), m_L);
    end
    if (ph == 7) begin
      chk("pt_addr", int'(pt_addr), k);
      chk("pt_wrdata", int'(pt_wrdata), int'(m_pt[k]));
    end
    if (ph == 4) begin
      chk("s_addr_i", int'(s_addr), int'(m_i[k]));
      chk("s_wrdata_i", int'(s_wrdata), int'(m_wi[k]));
    end
    if (ph == 5) begin
      chk("s_addr_j", int'(s_addr), int'(m_j[k]));
      chk("s_wrdata_j", int'(s_wrdata), int'(m_wj[k]));
    end
  endtask

  task automatic load();
    @(negedge clk) do_load = 1'b1;
    @(negedge clk) do_load = 1'b0;
  endtask

  // Runs one message; abort_at >= 0 asserts reset mid-cycle at that cycle index.
  task automatic run(input bit pulses, input int abort_at);
    int nbad, n0, p0;
    model();
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    for (int c = 0; c <= 2 + 8 * m_L; c++) begin
      @(negedge clk);
      compare(c);
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rdy", int'(rdy), 1);
        chk("abort_s_wren", int'(s_wren), 0);
        chk("abort_pt_wren", int'(pt_wren), 0);
        n0 = nswr; p0 = nptwr;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_s_writes", nswr, n0);
        chk("abort_no_pt_writes", nptwr, p0);
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      #1 en = (pulses && c < 8 * m_L - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    en = 1'b0;
    nbad = 0;
    for (int a = 0; a <= m_L; a++) if (pt_mem[a] != m_pt[a]) nbad++;
    chk("pt_mem_mismatches", nbad, 0);
    nbad = 0;
    for (int a = 0; a < 256; a++) if (S_mem[a] != m_S[a]) nbad++;
    chk("S_mem_mismatches", nbad, 0);
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) begin
      S_ld[a]  = 8'(a);
      ct_ld[a] = 8'h00;
    end
  endtask

  initial begin
    int n0;
    #13 rst_n = 1'b0;
    #1;
    chk("rst_rdy", int'(rdy), 1);
    chk("rst_s_wren", int'(s_wren), 0);
    chk("rst_pt_wren", int'(pt_wren), 0);
    chk("rst_ct_addr", int'(ct_addr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    set_identity();
    ct_ld[0] = 8'd1;
    load();
    run(1'b0, -1);
    chk("lit_pt0", int'(pt_mem[0]), 1);
    chk("lit_pt1", int'(pt_mem[1]), 8'h02);
    chk("lit_model_pt1", int'(m_pt[1]), 8'h02);
    chk("lit_S1_unchanged", int'(S_mem[1]), 1);

    set_identity();
    ct_ld[0] = 8'd2; ct_ld[1] = 8'h00; ct_ld[2] = 8'hFF;
    load();
    run(1'b0, -1);
    chk("lit2_pt1", int'(pt_mem[1]), 8'h02);
    chk("lit2_pt2", int'(pt_mem[2]), 8'hFA);
    chk("lit2_S2", int'(S_mem[2]), 3);
    chk("lit2_S3", int'(S_mem[3]), 2);

    set_identity();
    load();
    n0 = nswr;
    run(1'b0, -1);
    chk("len0_no_s_writes", nswr, n0);
    chk("len0_pt0", int'(pt_mem[0]), 0);

    set_identity();
    ct_ld[0] = 8'd255;
    load();
    run(1'b1, -1);

    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 256; a++) begin
        S_ld[a]  = 8'($urandom_range(0, 255));
        ct_ld[a] = 8'($urandom_range(0, 255));
      end
      ct_ld[0] = 8'($urandom_range(1, 40));
      load();
      run(1'b1, -1);
    end

    set_identity();
    ct_ld[0] = 8'd6;
    for (int a = 1; a <= 6; a++) ct_ld[a] = 8'($urandom_range(0, 255));
    load();
    run(1'b0, 22);
    S_ld = S_mem;
    load();
    run(1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
